// File: rtl/blackjack_pkg.sv
// Shared types and constants for the card dealer.
// Contents: deck/rank constants, card_t payload, dealer_state_t FSM encoding,
// and index_to_card() which maps a deck index to rank/suit.
// Optional feature macro: DEALER_FALLBACK_SCAN_EN (adds the SCAN state).
package blackjack_pkg;

  localparam int unsigned DEFAULT_DECK_SIZE = 52;
  localparam int unsigned RANKS_PER_SUIT    = 13;
  localparam int unsigned IDX_W             = 6;

  typedef struct packed {
    logic [3:0] rank;
    logic [1:0] suit;
  } card_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_CHECK   = 3'd2,
    ST_DELIVER = 3'd3
`ifdef DEALER_FALLBACK_SCAN_EN
    ,
    ST_SCAN    = 3'd4
`endif
  } dealer_state_t;

  // Index 0..12 is suit 0 ace..king, 13..25 suit 1, and so on.
  function automatic card_t index_to_card(input logic [IDX_W-1:0] index);
    card_t c;
    c.rank = 4'(index % IDX_W'(RANKS_PER_SUIT)) + 4'd1;
    c.suit = 2'(index / IDX_W'(RANKS_PER_SUIT));
    return c;
  endfunction

endpackage

// File: rtl/dealt_tracker.sv
// Bitmap of dealt cards plus the undealt-card counter.
// Ports: clk, reset_n (sync, active-low), clear (refill deck), mark/mark_index
// (record a dealt card), query_index -> query_dealt_c (combinational lookup,
// out-of-range indices read as dealt), cards_left, empty (registered).
module dealt_tracker
  import blackjack_pkg::*;
#(
  parameter int unsigned DECK_SIZE = DEFAULT_DECK_SIZE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             mark,
  input  logic [IDX_W-1:0] mark_index,
  input  logic [IDX_W-1:0] query_index,
  output logic             query_dealt_c,
  output logic [IDX_W-1:0] cards_left,
  output logic             empty
);

  logic [DECK_SIZE-1:0] bitmap;

  // Out-of-range indices are reported as dealt so they can never be accepted.
  always_comb begin
    query_dealt_c = 1'b1;
    if (query_index < IDX_W'(DECK_SIZE)) begin
      query_dealt_c = bitmap[query_index];
    end
  end

  // Bitmap and counter; clear beats mark. The FSM only marks undealt cards.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      bitmap     <= '0;
      cards_left <= IDX_W'(DECK_SIZE);
      empty      <= 1'b0;
    end else if (mark) begin
      bitmap[mark_index] <= 1'b1;
      cards_left         <= cards_left - IDX_W'(1);
      empty              <= (cards_left == IDX_W'(1));
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Random card dealer: draws indices from an external RNG, rejects out-of-range
// or already-dealt values, and delivers each card exactly once per shuffle.
// Ports: clk, reset_n (sync, active-low), deal_req, shuffle (pulses);
// rng_request -> rng_value (valid one cycle later); card_valid/card_rank/
// card_suit (registered, held between strobes); cards_left, deck_empty;
// deal_err (deal_req on an empty deck).
// Optional feature macro: DEALER_FALLBACK_SCAN_EN -- after MAX_TRIES
// consecutive rejections, linearly scan for an undealt card.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int unsigned DECK_SIZE = DEFAULT_DECK_SIZE,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       deal_req,
  input  logic       shuffle,
  output logic       rng_request,
  input  logic [5:0] rng_value,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       deal_err
);

  dealer_state_t    state, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] query_index_c;
  logic             query_dealt_c;
  logic             mark_c;
  logic             card_valid_d, deal_err_d, rng_request_d;
  card_t            card_q;

`ifdef DEALER_FALLBACK_SCAN_EN
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  logic [TRY_W-1:0] retry_q, retry_d;
  logic [IDX_W-1:0] scan_q, scan_d;
`else
  // MAX_TRIES has no effect without the fallback scan.
  if (MAX_TRIES == 0) begin : g_no_retry_budget
  end
`endif

  dealt_tracker #(.DECK_SIZE(DECK_SIZE)) u_tracker (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (shuffle),
    .mark         (mark_c),
    .mark_index   (idx_q),
    .query_index  (query_index_c),
    .query_dealt_c(query_dealt_c),
    .cards_left   (cards_left),
    .empty        (deck_empty)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state;
    idx_d         = idx_q;
    card_valid_d  = 1'b0;
    deal_err_d    = 1'b0;
    mark_c        = 1'b0;
    query_index_c = rng_value;
`ifdef DEALER_FALLBACK_SCAN_EN
    retry_d       = retry_q;
    scan_d        = scan_q;
    if (state == ST_SCAN) query_index_c = scan_q;
`endif
    if (shuffle) begin
      // Shuffle aborts everything, including a coincident deal_req.
      state_d = ST_IDLE;
`ifdef DEALER_FALLBACK_SCAN_EN
      retry_d = '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (deal_req) begin
            if (deck_empty) begin
              deal_err_d = 1'b1;
            end else begin
              state_d = ST_REQUEST;
`ifdef DEALER_FALLBACK_SCAN_EN
              retry_d = '0;
`endif
            end
          end
        end
        ST_REQUEST: state_d = ST_CHECK;
        ST_CHECK: begin
          if (!query_dealt_c) begin
            idx_d   = rng_value;
            state_d = ST_DELIVER;
          end else begin
`ifdef DEALER_FALLBACK_SCAN_EN
            if (retry_q == TRY_W'(MAX_TRIES - 1)) begin
              scan_d  = IDX_W'(32'(rng_value) % DECK_SIZE);
              state_d = ST_SCAN;
            end else begin
              retry_d = retry_q + TRY_W'(1);
              state_d = ST_REQUEST;
            end
`else
            state_d = ST_REQUEST;
`endif
          end
        end
`ifdef DEALER_FALLBACK_SCAN_EN
        ST_SCAN: begin
          if (!query_dealt_c) begin
            idx_d   = scan_q;
            state_d = ST_DELIVER;
          end else if (scan_q == IDX_W'(DECK_SIZE - 1)) begin
            scan_d = '0;
          end else begin
            scan_d = scan_q + IDX_W'(1);
          end
        end
`endif
        ST_DELIVER: begin
          card_valid_d = 1'b1;
          mark_c       = 1'b1;
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Registered request is high exactly while the FSM sits in REQUEST.
    rng_request_d = (state_d == ST_REQUEST);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      card_valid  <= 1'b0;
      deal_err    <= 1'b0;
      rng_request <= 1'b0;
      card_q      <= '0;
`ifdef DEALER_FALLBACK_SCAN_EN
      retry_q     <= '0;
      scan_q      <= '0;
`endif
    end else begin
      state       <= state_d;
      idx_q       <= idx_d;
      card_valid  <= card_valid_d;
      deal_err    <= deal_err_d;
      rng_request <= rng_request_d;
      if (card_valid_d) card_q <= index_to_card(idx_q);
`ifdef DEALER_FALLBACK_SCAN_EN
      retry_q     <= retry_d;
      scan_q      <= scan_d;
`endif
    end
  end

  assign card_rank = card_q.rank;
  assign card_suit = card_q.suit;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: RNG values and expected cards are queued,
// cards are scoreboarded as card_valid strobes arrive.
module tb_card_dealer;

  typedef struct {
    int idx;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       deal_req;
  logic       shuffle;
  logic       rng_request;
  logic [5:0] rng_value;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [5:0] cards_left;
  logic       deck_empty;
  logic       deal_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int deal_cyc = 0;
  int seen = 0;
  exp_t exp_q[$];
  logic [5:0] rng_q[$];

  card_dealer dut (
    .clk(clk), .reset_n(reset_n), .deal_req(deal_req), .shuffle(shuffle),
    .rng_request(rng_request), .rng_value(rng_value), .card_valid(card_valid),
    .card_rank(card_rank), .card_suit(card_suit), .cards_left(cards_left),
    .deck_empty(deck_empty), .deal_err(deal_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // RNG model: next queued value appears the cycle after rng_request.
  always @(negedge clk) begin
    if (rng_request === 1'b1 && rng_q.size() > 0) rng_value = rng_q.pop_front();
  end

  // Card monitor / scoreboard.
  always @(negedge clk) begin
    if (card_valid === 1'b1) begin
      chk("card_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("card_rank", 32'(card_rank), 32'((e.idx % 13) + 1));
        chk("card_suit", 32'(card_suit), 32'(e.idx / 13));
        if (e.lat >= 0) chk("card_latency", 32'(cyc - deal_cyc), 32'(e.lat));
      end
      seen++;
    end
  end

  // One deal: queue expectation, pulse deal_req, wait (bounded) for the card.
  task automatic deal(input int idx, input int lat);
    int seen0;
    exp_q.push_back('{idx, lat});
    seen0 = seen;
    @(negedge clk) deal_req = 1'b1;
    @(posedge clk) #1 deal_cyc = cyc;
    @(negedge clk) deal_req = 1'b0;
    for (int i = 0; i < 200 && seen == seen0; i++) @(posedge clk);
    chk("card_arrived", 32'(seen != seen0), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_shuffle();
    @(negedge clk) shuffle = 1'b1;
    @(negedge clk) shuffle = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; deal_req = 1'b0; shuffle = 1'b0; rng_value = '0;
    @(posedge clk); @(negedge clk);
    chk("rst_cards_left", 32'(cards_left), 32'd52);
    chk("rst_deck_empty", 32'(deck_empty), 32'd0);
    chk("rst_card_valid", 32'(card_valid), 32'd0);
    chk("rst_rng_request", 32'(rng_request), 32'd0);
    chk("rst_deal_err", 32'(deal_err), 32'd0);
    chk("rst_rank_suit", 32'({card_rank, card_suit}), 32'd0);
    reset_n = 1'b1;
    idle_cycles(2);

    // First-try accept of index 0.
    rng_q.push_back(6'd0);
    deal(0, 3);
    chk("left_after_1", 32'(cards_left), 32'd51);

    // Out-of-range value rejected once, then index 14.
    rng_q.push_back(6'd60); rng_q.push_back(6'd14);
    deal(14, 5);
    chk("left_after_2", 32'(cards_left), 32'd50);

    // Duplicate index rejected.
    rng_q.push_back(6'd5);
    deal(5, 3);
    rng_q.push_back(6'd5); rng_q.push_back(6'd6);
    deal(6, 5);
    chk("left_after_4", 32'(cards_left), 32'd48);

    // Shuffle while in CHECK aborts the deal.
    rng_q.push_back(6'd10);
    @(negedge clk) deal_req = 1'b1;
    @(negedge clk) deal_req = 1'b0;
    @(negedge clk) shuffle = 1'b1;
    @(negedge clk) shuffle = 1'b0;
    chk("shuffle_cards_left", 32'(cards_left), 32'd52);
    idle_cycles(6);

    // Simultaneous deal_req and shuffle: shuffle wins, no RNG request.
    @(negedge clk) begin deal_req = 1'b1; shuffle = 1'b1; end
    @(negedge clk) begin deal_req = 1'b0; shuffle = 1'b0; end
    for (int i = 0; i < 4; i++) begin
      chk("coincide_no_rng_req", 32'(rng_request), 32'd0);
      @(negedge clk);
    end

    // Reset during CHECK discards the deal and leaves the bitmap untouched.
    rng_q.push_back(6'd20);
    @(negedge clk) deal_req = 1'b1;
    @(negedge clk) deal_req = 1'b0;
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    chk("midreset_cards_left", 32'(cards_left), 32'd52);
    idle_cycles(6);
    rng_q.push_back(6'd20);
    deal(20, 3);
    chk("midreset_left_after", 32'(cards_left), 32'd51);

    // Full deck: 52 deals with the generator cycling 0..51.
    do_shuffle();
    for (int i = 0; i < 52; i++) begin
      rng_q.push_back(6'(i));
      deal(i, 3);
    end
    chk("full_cards_left", 32'(cards_left), 32'd0);
    chk("full_deck_empty", 32'(deck_empty), 32'd1);
    @(negedge clk) deal_req = 1'b1;
    @(negedge clk) deal_req = 1'b0;
    chk("empty_deal_err", 32'(deal_err), 32'd1);
    chk("empty_no_rng_req", 32'(rng_request), 32'd0);
    @(negedge clk);
    chk("empty_deal_err_pulse", 32'(deal_err), 32'd0);
    idle_cycles(6);

`ifdef DEALER_FALLBACK_SCAN_EN
    // Stuck generator forces SCAN to find the last undealt index.
    do_shuffle();
    for (int i = 0; i < 51; i++) begin
      rng_q.push_back(6'(i));
      deal(i, 3);
    end
    rng_value = 6'd0;
    deal(51, -1);
    chk("scan_deck_empty", 32'(deck_empty), 32'd1);
`endif

    idle_cycles(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 Parameter DECK_SIZE, default 52, number of distinct cards; indices 0..DECK_SIZE-1.
REQ-002 Parameter MAX_TRIES, default 8, rejected draws tolerated before fallback scan (used only when the macro in REQ-024 is defined).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 deal_req  input  1  single-cycle pulse requesting one card.
REQ-006 shuffle  input  1  single-cycle pulse returning all cards to the deck.
REQ-007 rng_request  output  1  pulse to the random number generator asking for a new value.
REQ-008 rng_value  input  6  generator output; valid the cycle after rng_request.
REQ-009 card_valid  output  1  one-cycle strobe; card_rank/card_suit valid while high.
REQ-010 card_rank  output  4  rank 1..13 (1 = ace, 11..13 = J/Q/K).
REQ-011 card_suit  output  2  suit 0..3.
REQ-012 cards_left  output  6  undealt card count.
REQ-013 deck_empty  output  1  high when cards_left == 0.
REQ-014 deal_err  output  1  one-cycle strobe when deal_req arrives with an empty deck.

Function
REQ-015 FSM states: IDLE, REQUEST, CHECK, DELIVER, plus SCAN when the REQ-024 macro is defined.
REQ-016 IDLE: deal_req with deck_empty low -> REQUEST. deal_req with deck_empty high -> deal_err high for one cycle, stay IDLE.
REQ-017 REQUEST: rng_request high for exactly one cycle -> CHECK. rng_request is low in every other state.
REQ-018 CHECK: sample rng_value. Reject if value >= DECK_SIZE or the card is already dealt, and return to REQUEST. Otherwise latch the index and go to DELIVER.
REQ-019 DELIVER: card_valid high for one cycle, mark the index dealt, decrement cards_left -> IDLE.
REQ-020 Latency: a first-try accept gives card_valid 3 cycles after deal_req is sampled; each rejection adds 2 cycles.
REQ-021 Index mapping: card_suit = index / 13, card_rank = (index mod 13) + 1. Outputs are registered and hold their last value when card_valid is low.
REQ-022 deal_req is ignored outside IDLE. No queueing.
REQ-023 shuffle in any state clears the dealt bitmap, sets cards_left = DECK_SIZE, clears the retry count, aborts any deal without asserting card_valid, and goes to IDLE next cycle. If shuffle and deal_req coincide, shuffle wins and deal_req is dropped.

Configuration
REQ-024 Macro DEALER_FALLBACK_SCAN_EN.
- Defined: after MAX_TRIES consecutive rejections, CHECK goes to SCAN. SCAN tests one index per cycle, starting at rng_value mod DECK_SIZE and incrementing with wrap from DECK_SIZE-1 to 0. The first undealt index goes to DELIVER. This bounds worst-case latency.
- Undefined: rejections retry indefinitely, and no retry counter or SCAN logic is synthesized.

Reset
REQ-025 reset_n low: state IDLE, bitmap cleared, cards_left = DECK_SIZE, deck_empty 0, card_valid 0, rng_request 0, deal_err 0, card_rank 0, card_suit 0, retry count 0.
REQ-026 Reset mid-deal discards the deal with no card_valid and no bitmap change after reset.

Structure
REQ-027 Package blackjack_pkg holds:
- the DECK_SIZE default and the RANKS_PER_SUIT = 13 constant;
- the card_t struct (rank[3:0], suit[1:0]);
- the dealer_state_t enum.
REQ-028 Sub-module dealt_tracker holds the DECK_SIZE-bit bitmap, with these ports:
- clear;
- mark + index;
- combinational query of index -> dealt;
- cards_left counter.
The FSM stays in card_dealer.

Verification
REQ-029 After reset, deal_req with rng_value = 0 -> card_valid 3 cycles later, rank 1, suit 0, cards_left 51.
REQ-030 rng_value = 60, then 14 -> one rejection, card_valid 5 cycles after deal_req, rank 2, suit 1.
REQ-031 Deal index 5, then deal again with rng_value = 5, then 6 -> second card is rank 7, suit 0; index 5 is not delivered twice.
REQ-032 52 deals with the generator cycling 0..51 -> deck_empty high, cards_left 0; a 53rd deal_req -> deal_err 1 cycle, no card_valid.
REQ-033 shuffle asserted in CHECK -> no card_valid, cards_left 52 next cycle. Simultaneous deal_req + shuffle in IDLE -> no rng_request.
REQ-034 With DEALER_FALLBACK_SCAN_EN, MAX_TRIES = 8, indices 0..50 dealt, rng_value stuck at 0 -> SCAN entered, card_valid with index 51 (rank 13, suit 3).
